// File: rtl/mmm_mac_ctrl_if.sv
// Bus bundle for mmm_mac_ctrl: run control, operand-memory reads, MAC control and result port.
// The master modport is the controller's view; the slave modport is the surrounding datapath's view.
interface mmm_mac_ctrl_if #(
    parameter int OUTW = 48,
    parameter int AWA  = 4,
    parameter int AWB  = 4
);
    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [AWA-1:0]  addr_a;
    logic [AWB-1:0]  addr_b;
    logic            valid_input;
    logic            clear_acc;
    logic [OUTW-1:0] mac_out;
    logic [OUTW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     run_cycles;

    modport master (
        input  start, mac_out, out_ready,
        output busy, done, rd_en, addr_a, addr_b, valid_input, clear_acc,
               out_data, out_valid, run_cycles
    );

    modport slave (
        output start, mac_out, out_ready,
        input  busy, done, rd_en, addr_a, addr_b, valid_input, clear_acc,
               out_data, out_valid, run_cycles
    );
endinterface

// File: rtl/mmm_mac_ctrl.sv
// Sequencer for C = A*B feeding mac_pipe: walks A/B memories, drains the MAC, captures each C element.
// Optional cycle counter on run_cycles is enabled by defining MMM_MAC_CTRL_PERF_EN.
module mmm_mac_ctrl #(
    parameter int INW  = 16,
    parameter int OUTW = 48,
    parameter int M    = 4,
    parameter int N    = 4,
    parameter int P    = 4,
    localparam int AWA = $clog2(M*N),
    localparam int AWB = $clog2(N*P)
) (
    input logic            clk,
    input logic            reset,
    mmm_mac_ctrl_if.master bus
);
    localparam int IW = $clog2(M);
    localparam int JW = $clog2(P);
    localparam int KW = $clog2(N);

    generate
        if (M < 2 || N < 2 || P < 2 || INW < 1) begin : g_badParams
            $error("mmm_mac_ctrl: M, N and P must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic            r_drainCnt;
    logic            r_validInput;
    logic [OUTW-1:0] r_outData;
    logic            r_outValid;

    logic w_lastI;
    logic w_lastJ;
    logic w_lastK;
    logic w_capture;
    logic w_busy;
    logic w_rdEn;
    logic w_clearAcc;
    logic w_done;

    assign w_lastI   = (r_i == IW'(M-1));
    assign w_lastJ   = (r_j == JW'(P-1));
    assign w_lastK   = (r_k == KW'(N-1));
    assign w_capture = (r_state == S_CAPTURE) && (!r_outValid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_nextState = S_ISSUE;
            S_ISSUE:   if (w_lastK) w_nextState = S_DRAIN;
            S_DRAIN:   if (r_drainCnt) w_nextState = S_CAPTURE;
            S_CAPTURE: if (w_capture) w_nextState = (w_lastI && w_lastJ) ? S_DONE : S_ISSUE;
            S_DONE:    w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // A stalled capture keeps clear_acc low so the finished sum survives in the MAC.
    always_comb begin
        w_busy     = 1'b0;
        w_rdEn     = 1'b0;
        w_clearAcc = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE:    w_clearAcc = 1'b1;
            S_ISSUE:   begin w_busy = 1'b1; w_rdEn = 1'b1; end
            S_DRAIN:   w_busy = 1'b1;
            S_CAPTURE: begin w_busy = 1'b1; w_clearAcc = w_capture; end
            S_DONE:    w_done = 1'b1;
            default:   w_clearAcc = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_drainCnt   <= 1'b0;
            r_validInput <= 1'b0;
        end else begin
            r_validInput <= w_rdEn;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_ISSUE: begin
                    r_k        <= w_lastK ? '0 : r_k + 1'b1;
                    r_drainCnt <= 1'b0;
                end
                S_DRAIN: r_drainCnt <= ~r_drainCnt;
                S_CAPTURE: begin
                    if (w_capture) begin
                        r_k <= '0;
                        if (w_lastJ) begin
                            r_j <= '0;
                            r_i <= w_lastI ? '0 : r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A capture and a handshake in the same cycle leave out_valid set with the new element.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_capture) begin
            r_outValid <= 1'b1;
            r_outData  <= bus.mac_out;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

`ifdef MMM_MAC_CTRL_PERF_EN
    logic [31:0] r_runCycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_runCycles <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_runCycles <= '0;
        end else if (w_busy && r_runCycles != 32'hFFFF_FFFF) begin
            r_runCycles <= r_runCycles + 32'd1;
        end
    end

    assign bus.run_cycles = r_runCycles;
`else
    assign bus.run_cycles = '0;
`endif

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.rd_en       = w_rdEn;
    assign bus.clear_acc   = w_clearAcc;
    assign bus.valid_input = r_validInput;
    assign bus.out_data    = r_outData;
    assign bus.out_valid   = r_outValid;
    assign bus.addr_a      = w_rdEn ? AWA'(int'(r_i) * N + int'(r_k)) : '0;
    assign bus.addr_b      = w_rdEn ? AWB'(int'(r_k) * P + int'(r_j)) : '0;
endmodule

// File: tb/tb_mmm_mac_ctrl.sv
// Directed bench for mmm_mac_ctrl on a 2x2x2 multiply, with behavioural operand memories and MAC.
// Expected C values and capture cycles are worked out by hand from the run timeline.
module tb_mmm_mac_ctrl;
    localparam int INW  = 16;
    localparam int OUTW = 48;
    localparam int M    = 2;
    localparam int N    = 2;
    localparam int P    = 2;
    localparam int AWA  = 2;
    localparam int AWB  = 2;
    localparam int MAXC = 40;
`ifdef MMM_MAC_CTRL_PERF_EN
    localparam logic [31:0] EXP_RUN = 32'd20;
`else
    localparam logic [31:0] EXP_RUN = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;

    mmm_mac_ctrl_if #(.OUTW(OUTW), .AWA(AWA), .AWB(AWB)) bus ();

    mmm_mac_ctrl #(.INW(INW), .OUTW(OUTW), .M(M), .N(N), .P(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [INW-1:0]  memA [4];
    logic [INW-1:0]  memB [4];
    logic [INW-1:0]  memAq;
    logic [INW-1:0]  memBq;
    logic [OUTW-1:0] macProd;
    logic [OUTW-1:0] macAcc;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            memAq <= memA[bus.addr_a];
            memBq <= memB[bus.addr_b];
        end
    end

    // Two-stage MAC: registered product, then accumulate or clear.
    always @(posedge clk) begin
        if (reset) begin
            macProd <= '0;
            macAcc  <= '0;
        end else begin
            macProd <= bus.valid_input ? OUTW'(memAq) * OUTW'(memBq) : '0;
            macAcc  <= bus.clear_acc ? '0 : macAcc + macProd;
        end
    end

    assign bus.mac_out = macAcc;

    int nChecks = 0;
    int nPassed = 0;

    logic [OUTW-1:0] expVals [4];
    logic [OUTW-1:0] sData     [MAXC+1];
    logic [AWA-1:0]  sAddrA    [MAXC+1];
    logic [AWB-1:0]  sAddrB    [MAXC+1];
    logic [31:0]     sRun      [MAXC+1];
    bit              sBusy     [MAXC+1];
    bit              sRdEn     [MAXC+1];
    bit              sClr      [MAXC+1];
    bit              sValid    [MAXC+1];
    bit              sOutValid [MAXC+1];
    bit              sDone     [MAXC+1];
    logic [OUTW-1:0] gotData [$];
    int              gotCyc  [$];
    int              doneCyc;
    int              doneCount;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed === expected) nPassed++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Cycle 0 is the cycle in which start is sampled; inputs change 2ns after each rising edge.
    task automatic applyStimulus(input int lowFrom, input int lowTo, input int pulseA,
                                 input int pulseB, input int resetAt, input int cycles);
        gotData.delete();
        gotCyc.delete();
        doneCyc   = -1;
        doneCount = 0;
        for (int c = 0; c <= cycles; c++) begin
            @(posedge clk);
            #2;
            bus.start     = (c == 0) || (c == pulseA) || (c == pulseB);
            reset         = (c == resetAt);
            bus.out_ready = !(c >= lowFrom && c <= lowTo);
            @(negedge clk);
            sData[c]     = bus.out_data;
            sAddrA[c]    = bus.addr_a;
            sAddrB[c]    = bus.addr_b;
            sRun[c]      = bus.run_cycles;
            sBusy[c]     = bus.busy;
            sRdEn[c]     = bus.rd_en;
            sClr[c]      = bus.clear_acc;
            sValid[c]    = bus.valid_input;
            sOutValid[c] = bus.out_valid;
            sDone[c]     = bus.done;
            if (bus.done) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (bus.out_valid && bus.out_ready) begin
                gotData.push_back(bus.out_data);
                gotCyc.push_back(c);
            end
        end
        @(posedge clk);
        #2;
        bus.start     = 1'b0;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic checkSequence(input string tag, input int c0, input int c1,
                                 input int c2, input int c3);
        int expCyc [4];
        expCyc[0] = c0;
        expCyc[1] = c1;
        expCyc[2] = c2;
        expCyc[3] = c3;
        checkOutput({tag, " count"}, 64'(gotData.size()), 64'd4);
        for (int e = 0; e < 4 && e < gotData.size(); e++) begin
            checkOutput($sformatf("%s data%0d", tag, e), 64'(gotData[e]), 64'(expVals[e]));
            checkOutput($sformatf("%s cycle%0d", tag, e), 64'(gotCyc[e]), 64'(expCyc[e]));
        end
    endtask

    initial begin
        memA[0] = 16'd1; memA[1] = 16'd2; memA[2] = 16'd3; memA[3] = 16'd4;
        memB[0] = 16'd5; memB[1] = 16'd6; memB[2] = 16'd7; memB[3] = 16'd8;
        expVals[0] = 48'd19; expVals[1] = 48'd22; expVals[2] = 48'd43; expVals[3] = 48'd50;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst busy",      64'(bus.busy),        64'd0);
        checkOutput("rst done",      64'(bus.done),        64'd0);
        checkOutput("rst rd_en",     64'(bus.rd_en),       64'd0);
        checkOutput("rst valid_in",  64'(bus.valid_input), 64'd0);
        checkOutput("rst clear_acc", 64'(bus.clear_acc),   64'd1);
        checkOutput("rst out_valid", 64'(bus.out_valid),   64'd0);
        checkOutput("rst out_data",  64'(bus.out_data),    64'd0);
        checkOutput("rst run_cyc",   64'(bus.run_cycles),  64'd0);

        // Plain run, downstream always ready.
        applyStimulus(-1, -2, -1, -1, -1, 24);
        checkSequence("basic", 6, 11, 16, 21);
        checkOutput("basic done cycle", 64'(doneCyc),   64'd21);
        checkOutput("basic done count", 64'(doneCount), 64'd1);
        checkOutput("basic addr_a c1",  64'(sAddrA[1]), 64'd0);
        checkOutput("basic addr_a c2",  64'(sAddrA[2]), 64'd1);
        checkOutput("basic addr_b c1",  64'(sAddrB[1]), 64'd0);
        checkOutput("basic addr_b c2",  64'(sAddrB[2]), 64'd2);
        checkOutput("basic addr_b c6",  64'(sAddrB[6]), 64'd1);
        checkOutput("basic addr_b c7",  64'(sAddrB[7]), 64'd3);
        checkOutput("basic addr_a c11", 64'(sAddrA[11]), 64'd2);
        checkOutput("basic addr_a c17", 64'(sAddrA[17]), 64'd3);
        checkOutput("basic rd_en c3",   64'(sRdEn[3]),  64'd0);
        checkOutput("basic valid c3",   64'(sValid[3]), 64'd1);
        checkOutput("basic valid c4",   64'(sValid[4]), 64'd0);
        checkOutput("basic clear c4",   64'(sClr[4]),   64'd0);
        checkOutput("basic clear c5",   64'(sClr[5]),   64'd1);
        checkOutput("basic busy c20",   64'(sBusy[20]), 64'd1);
        checkOutput("basic busy c21",   64'(sBusy[21]), 64'd0);
        checkOutput("basic run_cycles at done", 64'(sRun[21]), 64'(EXP_RUN));
        checkOutput("basic run_cycles held",    64'(sRun[24]), 64'(EXP_RUN));

        // Downstream stalls during cycles 6..15.
        applyStimulus(6, 15, -1, -1, -1, 30);
        checkSequence("backpressure", 16, 17, 22, 27);
        checkOutput("bp done cycle",   64'(doneCyc),      64'd27);
        checkOutput("bp data c8",      64'(sData[8]),     64'd19);
        checkOutput("bp data c15",     64'(sData[15]),    64'd19);
        checkOutput("bp out_valid c12", 64'(sOutValid[12]), 64'd1);
        checkOutput("bp busy c12",     64'(sBusy[12]),    64'd1);
        checkOutput("bp rd_en c12",    64'(sRdEn[12]),    64'd0);
        checkOutput("bp clear c12",    64'(sClr[12]),     64'd0);

        // start pulses while busy must be ignored.
        applyStimulus(-1, -2, 3, 12, -1, 24);
        checkSequence("start busy", 6, 11, 16, 21);
        checkOutput("start busy done count", 64'(doneCount), 64'd1);

        // Reset during ISSUE.
        applyStimulus(-1, -2, -1, -1, 2, 6);
        checkOutput("rst issue busy",      64'(sBusy[3]),     64'd0);
        checkOutput("rst issue out_valid", 64'(sOutValid[3]), 64'd0);
        checkOutput("rst issue rd_en",     64'(sRdEn[3]),     64'd0);
        checkOutput("rst issue done",      64'(sDone[3]),     64'd0);
        checkOutput("rst issue clear",     64'(sClr[3]),      64'd1);

        // Reset at cycle 8 with an unconsumed element pending, then a fresh run.
        applyStimulus(6, 12, -1, -1, 8, 24);
        checkOutput("rst mid out_valid c8", 64'(sOutValid[8]), 64'd1);
        checkOutput("rst mid out_valid c9", 64'(sOutValid[9]), 64'd0);
        checkOutput("rst mid busy c9",      64'(sBusy[9]),     64'd0);
        checkOutput("rst mid handshakes",   64'(gotData.size()), 64'd0);
        checkOutput("rst mid done count",   64'(doneCount),    64'd0);
        applyStimulus(-1, -2, -1, -1, -1, 24);
        checkSequence("restart", 6, 11, 16, 21);
        checkOutput("restart done cycle", 64'(doneCyc), 64'd21);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end
endmodule
